egress_scheduler: RTL

- Per-egress-port read side of the VOQ fabric. One instance per egress port.
- Watches the NUM_PORTS per-ingress VOQs that the crossbar fills for this port.
- Picks one non-empty VOQ by round-robin, pops its head frame pointer, and offers it to the egress frame reader with a valid/ready handshake.
- Holds off the next grant until the reader reports the frame fully transmitted.

---
 rtl/mem_pkg.sv | 4 +
 rtl/switch_pkg.sv | 11 +
 rtl/egress_scheduler_rr_arbiter.sv | 28 ++
 rtl/egress_scheduler.sv | 106 ++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Packet-memory geometry shared across the switch datapath.
package mem_pkg;
  localparam int ADDR_W = 10;
endpackage

// File: rtl/switch_pkg.sv
// Switch-wide sizing and shared egress-side types.
package switch_pkg;
  localparam int NUM_PORTS = 4;
  localparam int PORT_W    = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    WAIT_TX
  } egress_sched_state_t;
endpackage

// File: rtl/egress_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above rr_ptr, wrapping.
module rr_arbiter #(
  parameter  int NUM_PORTS = 4,
  localparam int PW        = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PW-1:0]        rr_ptr,
  output logic [PW-1:0]        grant_idx,
  output logic                 grant_valid
);

  logic [PW-1:0] w_idx;

  // Explicit wrap compare keeps non-power-of-2 port counts correct.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    w_idx       = rr_ptr;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!grant_valid && req[w_idx]) begin
        grant_idx   = w_idx;
        grant_valid = 1'b1;
      end
      w_idx = (w_idx == PW'(NUM_PORTS - 1)) ? '0 : w_idx + PW'(1);
    end
  end

endmodule

// File: rtl/egress_scheduler.sv
// Per-egress-port VOQ scheduler: round-robin grant, pop strobe, offer handshake,
// and hold-off until the reader signals frame completion.
module egress_scheduler
  import switch_pkg::*;
#(
  parameter  int NUM_PORTS = switch_pkg::NUM_PORTS,
  parameter  int ADDR_W    = mem_pkg::ADDR_W,
  parameter  int CNT_W     = 32,
  localparam int PW        = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] voq_not_empty_i,
  input  logic [ADDR_W-1:0]    voq_head_ptrs_i [NUM_PORTS-1:0],
  output logic [NUM_PORTS-1:0] voq_pop_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic [ADDR_W-1:0]    tx_start_ptr_o,
  output logic [PW-1:0]        tx_src_port_o,
  input  logic                 tx_done_i,
  output logic                 busy_o,
  output logic [CNT_W-1:0]     frames_sent_o
);

  egress_sched_state_t r_state, w_next;

  logic [PW-1:0]        r_rr_ptr;
  logic [NUM_PORTS-1:0] r_pop;
  logic                 r_valid;
  logic [ADDR_W-1:0]    r_start;
  logic [PW-1:0]        r_src;
  logic                 r_busy;
  logic [CNT_W-1:0]     r_cnt;

  logic [PW-1:0]        w_gidx;
  logic                 w_gvalid;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .req         (voq_not_empty_i),
    .rr_ptr      (r_rr_ptr),
    .grant_idx   (w_gidx),
    .grant_valid (w_gvalid)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_gvalid)   w_next = OFFER;
      OFFER:   if (tx_ready_i) w_next = WAIT_TX;
      WAIT_TX: if (tx_done_i)  w_next = IDLE;
      default:                 w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != IDLE);
    end
  end

  // The pop strobe defaults low so it is high only in the first OFFER cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_pop    <= '0;
      r_valid  <= 1'b0;
      r_start  <= '0;
      r_src    <= '0;
      r_cnt    <= '0;
    end else begin
      r_pop <= '0;
      case (r_state)
        IDLE: begin
          if (w_gvalid) begin
            r_start <= voq_head_ptrs_i[w_gidx];
            r_src   <= w_gidx;
            r_pop   <= NUM_PORTS'(1) << w_gidx;
            r_valid <= 1'b1;
          end
        end
        OFFER: begin
          if (tx_ready_i) r_valid <= 1'b0;
        end
        WAIT_TX: begin
          if (tx_done_i) begin
            r_cnt    <= r_cnt + CNT_W'(1);
            r_rr_ptr <= (r_src == PW'(NUM_PORTS - 1)) ? '0 : r_src + PW'(1);
          end
        end
        default: r_valid <= 1'b0;
      endcase
    end
  end

  assign voq_pop_o      = r_pop;
  assign tx_valid_o     = r_valid;
  assign tx_start_ptr_o = r_start;
  assign tx_src_port_o  = r_src;
  assign busy_o         = r_busy;
  assign frames_sent_o  = r_cnt;

endmodule
